keypad_code_entry: RTL and testbench
====================================

Name: keypad_code_entry

Overview:
- Parametrised keypad digit accumulator; next generation of the lock's single-register keypress accumulator.
- Sits between the keypad scanner (key code + press level) and the lock comparator.
- Adds bounded digit count, backspace via multi-cycle recompute, clear, explicit error state, and a valid/ready submit handshake so the comparator consumes each code exactly once.

Parameters:
- DIGITS, 6: maximum digits per code.
- BASE, 10: radix used for accumulation.
- KEY_W, 8: key code width.
- OUT_W, 32: width of typed; must hold BASE^DIGITS-1 and ERR_CODE.
- MIN_KEY, 1: lowest valid digit key code (inclusive).
- MAX_KEY, 6: highest valid digit key code (inclusive); MAX_KEY < BASE.
- BKSP_KEY, 10: backspace code.
- CLR_KEY, 11: clear code.
- ENTER_KEY, 12: submit code.
- ERR_CODE, 9999999: value shown on typed while in ERROR.

Ports:
- hwclk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  entry enable; low clears and holds the block idle.
- button_pressed  in  1  level, high while a key is held.
- key  in  KEY_W  code of the held key; valid while button_pressed is high.
- typed  out  OUT_W  current accumulated value, or ERR_CODE.
- digit_count  out  $clog2(DIGITS+1)  digits currently entered.
- full  out  1  digit_count == DIGITS.
- busy  out  1  high in RECALC.
- error  out  1  high in ERROR.
- code_valid  out  1  submitted code present on typed.
- code_ready  in  1  consumer accepts the code.

Behaviour:
- Reset (rst_n low, async): state OFF; typed=0, digit_count=0, digit buffer=0, prev_press=0; all flags 0.
- Press event: button_pressed & !prev_press. prev_press <= button_pressed every cycle in every state, including OFF. At most one event per press.
- enable low: synchronous, highest priority after reset. Next state OFF; typed, count and buffer cleared; code_valid dropped, even mid-SUBMIT or mid-RECALC.
- OFF: when enable is high, go to ENTRY next cycle. Presses are ignored in OFF.
- ENTRY, on a press event:
  - Digit key (MIN_KEY<=key<=MAX_KEY):
    - If count<DIGITS: buffer[count]<=key; count+1; typed<=typed*BASE+key (OUT_W-bit arithmetic). Visible the next cycle.
    - If full: ignored; typed unchanged.
  - BKSP_KEY:
    - If count>0: count-1; go to RECALC.
    - Else: ignored.
  - CLR_KEY: typed=0, count=0; stay in ENTRY.
  - ENTER_KEY:
    - If count>0: go to SUBMIT; code_valid=1 from the next cycle.
    - Else: ignored.
  - Any other code: go to ERROR; typed<=ERR_CODE.
- RECALC:
  - busy=1; typed holds its stale value; accumulator and index start at 0.
  - Each cycle, while index<count: acc<=acc*BASE+buffer[index]; index+1.
  - When index==count: typed<=acc; go to ENTRY.
  - Occupancy is count+1 cycles (count after decrement); count 0 takes 1 cycle with typed=0.
  - Press events during RECALC are dropped.
- ERROR: error=1; typed=ERR_CODE. CLR_KEY press -> ENTRY with typed=0, count=0. All other presses are ignored.
- SUBMIT:
  - code_valid=1; typed and count held stable.
  - On a cycle with code_ready=1: clear typed and count; drop code_valid next cycle; go to ENTRY.
  - Press events during SUBMIT are dropped.
  - code_ready high before code_valid has no effect.
- full and error are combinational from registered state; no glitching from key.

Test Plan:
- Reset, enable=1; presses 3,5,1 -> typed=351, digit_count=3, full=0, code_valid=0.
- Presses 1,2,3,4,5,6, then 6 again (DIGITS=6) -> typed=123456, full=1; 7th press ignored, typed stays 123456.
- Presses 4,2,5 then BKSP -> busy high exactly 3 cycles (count=2), then typed=42, digit_count=2. Press during busy is dropped.
- Press 9 -> error=1, typed=9999999. Press 3 ignored. CLR -> typed=0, error=0.
- Presses 2,6 then ENTER, code_ready low 5 cycles -> code_valid held, typed=26. code_ready pulse -> code_valid low next cycle, typed=0. ENTER with count 0 -> no code_valid.
- button_pressed held high 20 cycles with key=3 -> single digit appended. Drop enable during SUBMIT -> code_valid=0, typed=0 next cycle. rst_n low mid-RECALC -> outputs zero immediately (async).

Source files
------------

// File: rtl/keypad_code_entry.sv
// Keypad digit accumulator: collects digit presses into a base-BASE value, supports
// backspace (by replaying the stored digits), clear, an error state and a valid/ready submit.
module keypad_code_entry #(
  parameter int DIGITS    = 6,
  parameter int BASE      = 10,
  parameter int KEY_W     = 8,
  parameter int OUT_W     = 32,
  parameter int MIN_KEY   = 1,
  parameter int MAX_KEY   = 6,
  parameter int BKSP_KEY  = 10,
  parameter int CLR_KEY   = 11,
  parameter int ENTER_KEY = 12,
  parameter int ERR_CODE  = 9999999,
  localparam int CNT_W    = $clog2(DIGITS + 1),
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             hwclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             button_pressed,
  input  logic [KEY_W-1:0] key,
  output logic [OUT_W-1:0] typed,
  output logic [CNT_W-1:0] digit_count,
  output logic             full,
  output logic             busy,
  output logic             error,
  output logic             code_valid,
  input  logic             code_ready
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ENTRY  = 3'd1,
    S_RECALC = 3'd2,
    S_SUBMIT = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   typed_q, typed_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [KEY_W-1:0]   buf_q [DIGITS];
  logic [KEY_W-1:0]   buf_d [DIGITS];
  logic               prev_q;

  logic press;
  logic is_digit;

  assign press    = button_pressed & ~prev_q;
  assign is_digit = (key >= KEY_W'(MIN_KEY)) && (key <= KEY_W'(MAX_KEY));

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      typed_q <= '0;
      count_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      prev_q  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      typed_q <= typed_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      prev_q  <= button_pressed;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    typed_d = typed_q;
    count_d = count_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    for (int i = 0; i < DIGITS; i++) buf_d[i] = buf_q[i];

    if (!enable) begin
      state_d = S_OFF;
      typed_d = '0;
      count_d = '0;
      acc_d   = '0;
      idx_d   = '0;
      for (int i = 0; i < DIGITS; i++) buf_d[i] = '0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_ENTRY;

        S_ENTRY: begin
          if (press) begin
            if (is_digit) begin
              if (count_q < CNT_W'(DIGITS)) begin
                buf_d[count_q[IDX_W-1:0]] = key;
                count_d = count_q + CNT_W'(1);
                typed_d = typed_q * OUT_W'(BASE) + OUT_W'(key);
              end
            end else if (key == KEY_W'(BKSP_KEY)) begin
              if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
                acc_d   = '0;
                idx_d   = '0;
                state_d = S_RECALC;
              end
            end else if (key == KEY_W'(CLR_KEY)) begin
              typed_d = '0;
              count_d = '0;
            end else if (key == KEY_W'(ENTER_KEY)) begin
              if (count_q != '0) state_d = S_SUBMIT;
            end else begin
              state_d = S_ERROR;
              typed_d = OUT_W'(ERR_CODE);
            end
          end
        end

        // Rebuild the value from the surviving digits, one digit per cycle.
        S_RECALC: begin
          if (idx_q < count_q) begin
            acc_d = acc_q * OUT_W'(BASE) + OUT_W'(buf_q[idx_q[IDX_W-1:0]]);
            idx_d = idx_q + CNT_W'(1);
          end else begin
            typed_d = acc_q;
            state_d = S_ENTRY;
          end
        end

        S_SUBMIT: begin
          if (code_ready) begin
            typed_d = '0;
            count_d = '0;
            state_d = S_ENTRY;
          end
        end

        S_ERROR: begin
          if (press && (key == KEY_W'(CLR_KEY))) begin
            typed_d = '0;
            count_d = '0;
            state_d = S_ENTRY;
          end
        end

        default: state_d = S_OFF;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == S_RECALC);
    error      = (state_q == S_ERROR);
    code_valid = (state_q == S_SUBMIT);
    full       = (count_q == CNT_W'(DIGITS));
  end

  assign typed       = typed_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: directed scenarios plus random key sequences checked
// against a digit-list model; submitted codes are checked by a handshake monitor.
module tb_keypad_code_entry;

  localparam int          KEY_W = 8;
  localparam int          OUT_W = 32;
  localparam logic [31:0] ERR   = 32'd9999999;
  localparam logic [7:0]  BKSP  = 8'd10;
  localparam logic [7:0]  CLR   = 8'd11;
  localparam logic [7:0]  ENTER = 8'd12;

  logic             hwclk;
  logic             rst_n;
  logic             enable;
  logic             button_pressed;
  logic [KEY_W-1:0] key;
  logic [OUT_W-1:0] typed;
  logic [2:0]       digit_count;
  logic             full;
  logic             busy;
  logic             error;
  logic             code_valid;
  logic             code_ready;

  keypad_code_entry dut (
    .hwclk          (hwclk),
    .rst_n          (rst_n),
    .enable         (enable),
    .button_pressed (button_pressed),
    .key            (key),
    .typed          (typed),
    .digit_count    (digit_count),
    .full           (full),
    .busy           (busy),
    .error          (error),
    .code_valid     (code_valid),
    .code_ready     (code_ready)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          digs[$];
  bit          merr;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic press(input logic [7:0] k, input int hold);
    key            = k;
    button_pressed = 1'b1;
    repeat (hold) tick();
    button_pressed = 1'b0;
    tick();
    wait_idle();
  endtask

  function automatic logic [31:0] model_val();
    logic [31:0] v = 32'd0;
    if (merr) return ERR;
    foreach (digs[i]) v = v * 32'd10 + 32'(digs[i]);
    return v;
  endfunction

  // Returns 1 when the key submits a code (the code is queued for the monitor).
  function automatic bit model_step(input logic [7:0] k);
    if (merr) begin
      if (k == CLR) begin
        merr = 1'b0;
        digs.delete();
      end
      return 1'b0;
    end
    if (k >= 8'd1 && k <= 8'd6) begin
      if (digs.size() < 6) digs.push_back(int'(k));
    end else if (k == BKSP) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (k == CLR) begin
      digs.delete();
    end else if (k == ENTER) begin
      if (digs.size() > 0) begin
        exp_q.push_back(model_val());
        return 1'b1;
      end
    end else begin
      merr = 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] pick_key();
    int r = int'($urandom_range(0, 99));
    if (r < 60) return 8'($urandom_range(1, 6));
    if (r < 70) return BKSP;
    if (r < 79) return CLR;
    if (r < 89) return ENTER;
    case ($urandom_range(0, 5))
      0: return 8'd0;
      1: return 8'd7;
      2: return 8'd8;
      3: return 8'd9;
      4: return 8'd13;
      default: return 8'd200;
    endcase
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_typed"}, typed, model_val());
    chk({tag, "_error"}, error, merr);
    if (!merr) begin
      chk({tag, "_count"}, digit_count, digs.size());
      chk({tag, "_full"}, full, digs.size() == 6);
    end
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Handshake monitor: each presented code must match the oldest queued expectation.
  logic cv_prev = 1'b0;
  always @(negedge hwclk) begin
    if (rst_n) begin
      if (code_valid && !cv_prev) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("valid_typed", typed, exp_q[0]);
      end
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) chk("spurious_accept", 1, 0);
        else chk("accepted_code", typed, exp_q.pop_front());
      end
    end
    cv_prev = code_valid;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    rst_n          = 1'b0;
    enable         = 1'b0;
    button_pressed = 1'b0;
    key            = '0;
    code_ready     = 1'b0;
    repeat (3) tick();
    chk("rst_typed", typed, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_flags", {full, busy, error, code_valid}, 0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    repeat (2) tick();

    press(8'd3, 1); press(8'd5, 1); press(8'd1, 1);
    chk("t351_typed", typed, 351);
    chk("t351_count", digit_count, 3);
    chk("t351_full", full, 0);
    chk("t351_valid", code_valid, 0);

    press(CLR, 1);
    for (int d = 1; d <= 6; d++) press(8'(d), 1);
    chk("full_typed", typed, 123456);
    chk("full_flag", full, 1);
    press(8'd6, 1);
    chk("full_ignore_typed", typed, 123456);
    chk("full_ignore_count", digit_count, 6);

    press(CLR, 1);
    press(8'd4, 1); press(8'd2, 1); press(8'd5, 1);
    key            = BKSP;
    button_pressed = 1'b1;
    tick();
    chk("recalc_stale_typed", typed, 425);
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      if (nb == 1) button_pressed = 1'b0;
      if (nb == 2) begin
        key            = 8'd3;
        button_pressed = 1'b1;
      end
      tick();
    end
    button_pressed = 1'b0;
    tick();
    chk("bksp_busy_cycles", nb, 3);
    chk("bksp_typed", typed, 42);
    chk("bksp_count", digit_count, 2);

    press(8'd9, 1);
    chk("err_flag", error, 1);
    chk("err_typed", typed, ERR);
    press(8'd3, 1);
    chk("err_ignore_typed", typed, ERR);
    press(CLR, 1);
    chk("err_clr_typed", typed, 0);
    chk("err_clr_flag", error, 0);

    press(8'd2, 1); press(8'd6, 1);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    chk("early_ready_typed", typed, 26);
    chk("early_ready_count", digit_count, 2);
    exp_q.push_back(32'd26);
    press(ENTER, 1);
    for (int i = 0; i < 5; i++) begin
      chk("submit_hold_valid", code_valid, 1);
      chk("submit_hold_typed", typed, 26);
      tick();
    end
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    chk("accept_valid_low", code_valid, 0);
    chk("accept_typed", typed, 0);
    chk("accept_count", digit_count, 0);
    press(ENTER, 1);
    tick();
    chk("enter_empty_valid", code_valid, 0);

    press(8'd3, 20);
    chk("hold_count", digit_count, 1);
    chk("hold_typed", typed, 3);

    exp_q.push_back(32'd3);
    press(ENTER, 1);
    chk("pre_drop_valid", code_valid, 1);
    enable = 1'b0;
    tick();
    chk("drop_valid", code_valid, 0);
    chk("drop_typed", typed, 0);
    chk("drop_count", digit_count, 0);
    void'(exp_q.pop_back());
    enable = 1'b1;
    repeat (2) tick();

    press(8'd1, 1); press(8'd2, 1); press(8'd3, 1); press(8'd4, 1);
    key            = BKSP;
    button_pressed = 1'b1;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_typed", typed, 0);
    chk("async_rst_count", digit_count, 0);
    chk("async_rst_flags", {full, busy, error, code_valid}, 0);
    button_pressed = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    digs.delete();
    merr = 1'b0;
    chk_status("rand_start");
    for (int n = 0; n < 250; n++) begin
      logic [7:0] k;
      bit         sub;
      k   = pick_key();
      sub = model_step(k);
      press(k, int'($urandom_range(1, 3)));
      if (sub) begin
        chk("rand_submit_valid", code_valid, 1);
        repeat ($urandom_range(0, 4)) tick();
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        digs.delete();
        chk("rand_accept_valid", code_valid, 0);
      end
      chk_status("rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    chk("codes_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
